// File: rtl/lcd_timing_pkg.sv
// Shared LCD panel timing constants and the row-driver controller state type.
package lcd_timing_pkg;

    localparam int DOTS      = 456;
    localparam int LINES     = 154;
    localparam int VIS_LINES = 144;
    localparam int CK_W      = 4;
    localparam int GAP       = 2;
    localparam int FR_PERIOD = 13;
    localparam int LY_W      = $clog2(LINES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ydrv_state_e;

endpackage

// File: rtl/ydriver_ctrl_if.sv
// Control bundle between the LCD controller core and the row (Y) driver control block.
interface ydriver_ctrl_if #(
    parameter int LY_W = lcd_timing_pkg::LY_W
);
    // en is a plain level: no handshake, sampled every clock; all other signals are
    // registered outputs of the controller, valid in every cycle.
    logic            en;
    logic            s;
    logic            ck;
    logic            cck;
    logic            fr;
    logic [LY_W-1:0] ly;
    logic            line_start;
    logic            frame_start;
    logic            vblank;

    modport master (
        output en,
        input  s, ck, cck, fr, ly, line_start, frame_start, vblank
    );

    modport slave (
        input  en,
        output s, ck, cck, fr, ly, line_start, frame_start, vblank
    );
endinterface

// File: rtl/ydriver_phase_gen.sv
// Two-phase non-overlapping shift clock generator: decodes a dot index into registered ck/cck.
module ydriver_phase_gen #(
    parameter int DOTS = lcd_timing_pkg::DOTS,
    parameter int CK_W = lcd_timing_pkg::CK_W,
    parameter int GAP  = lcd_timing_pkg::GAP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run_i,
    input  logic [$clog2(DOTS)-1:0] dot_i,
    output logic                    ck_o,
    output logic                    cck_o
);
    localparam int DOT_W = $clog2(DOTS);

    logic ck_q, ck_d;
    logic cck_q, cck_d;

    // cck idles high so the chain is parked in phase B whenever the scan is stopped.
    always_comb begin
        ck_d  = 1'b0;
        cck_d = 1'b1;
        if (run_i) begin
            ck_d  = (dot_i >= DOT_W'(GAP)) && (dot_i <= DOT_W'(GAP + CK_W - 1));
            cck_d = (dot_i >= DOT_W'(2 * GAP + CK_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ck_q  <= 1'b0;
            cck_q <= 1'b1;
        end else begin
            ck_q  <= ck_d;
            cck_q <= cck_d;
        end
    end

    assign ck_o  = ck_q;
    assign cck_o = cck_q;

endmodule

// File: rtl/ydriver_ctrl.sv
// LCD row driver control: IDLE/RUN scan FSM, dot/line/polarity counters and registered decode.
module ydriver_ctrl
    import lcd_timing_pkg::*;
#(
    parameter int DOTS      = lcd_timing_pkg::DOTS,
    parameter int LINES     = lcd_timing_pkg::LINES,
    parameter int VIS_LINES = lcd_timing_pkg::VIS_LINES,
    parameter int CK_W      = lcd_timing_pkg::CK_W,
    parameter int GAP       = lcd_timing_pkg::GAP,
    parameter int FR_PERIOD = lcd_timing_pkg::FR_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ydriver_ctrl_if.slave        bus,
    output ydrv_state_e          state_o
);
    localparam int DOT_W = $clog2(DOTS);
    localparam int LIN_W = $clog2(LINES);
    localparam int FRC_W = (FR_PERIOD > 1) ? $clog2(FR_PERIOD) : 1;

    if (2 * GAP + CK_W >= DOTS) begin : g_bad_dots
        $error("ydriver_ctrl: ck/cck windows do not fit in one line");
    end
    if (VIS_LINES > LINES) begin : g_bad_vis
        $error("ydriver_ctrl: VIS_LINES exceeds LINES");
    end
    if (FR_PERIOD < 1) begin : g_bad_fr
        $error("ydriver_ctrl: FR_PERIOD must be at least 1");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("ydriver_ctrl: GAP must be at least 1");
    end

    ydrv_state_e      state_q, state_d;
    logic [DOT_W-1:0] dot_q, dot_d;
    logic [LIN_W-1:0] line_q, line_d;
    logic [FRC_W-1:0] fr_cnt_q, fr_cnt_d;
    logic             fr_q, fr_d;
    logic             s_q, ls_q, fs_q, vb_q;
    logic [LIN_W-1:0] ly_q;
    logic             run_d;
    logic             dot_wrap;

    always_comb begin
        state_d  = state_q;
        dot_d    = '0;
        line_d   = '0;
        fr_cnt_d = '0;
        fr_d     = 1'b0;
        dot_wrap = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.en)  state_d = ST_RUN;
            ST_RUN:  if (!bus.en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Counters only advance while staying in RUN; entering or leaving RUN lands on reset values.
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            dot_wrap = (dot_q == DOT_W'(DOTS - 1));
            dot_d    = dot_wrap ? '0 : dot_q + 1'b1;
            line_d   = line_q;
            fr_cnt_d = fr_cnt_q;
            fr_d     = fr_q;
            if (dot_wrap) begin
                line_d = (line_q == LIN_W'(LINES - 1)) ? '0 : line_q + 1'b1;
                if (fr_cnt_q == FRC_W'(FR_PERIOD - 1)) begin
                    fr_cnt_d = '0;
                    fr_d     = ~fr_q;
                end else begin
                    fr_cnt_d = fr_cnt_q + 1'b1;
                end
            end
        end
    end

    assign run_d = (state_d == ST_RUN);

    // Outputs decode the next-state counters so each registered output lines up with its own dot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dot_q    <= '0;
            line_q   <= '0;
            fr_cnt_q <= '0;
            fr_q     <= 1'b0;
            s_q      <= 1'b0;
            ly_q     <= '0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            vb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dot_q    <= dot_d;
            line_q   <= line_d;
            fr_cnt_q <= fr_cnt_d;
            fr_q     <= fr_d;
            s_q      <= run_d && (line_d == '0);
            ly_q     <= line_d;
            ls_q     <= run_d && (dot_d == '0);
            fs_q     <= run_d && (dot_d == '0) && (line_d == '0);
            vb_q     <= run_d && ({1'b0, line_d} >= (LIN_W + 1)'(VIS_LINES));
        end
    end

    ydriver_phase_gen #(
        .DOTS (DOTS),
        .CK_W (CK_W),
        .GAP  (GAP)
    ) u_phase_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run_i (run_d),
        .dot_i (dot_d),
        .ck_o  (bus.ck),
        .cck_o (bus.cck)
    );

    assign bus.s           = s_q;
    assign bus.fr          = fr_q;
    assign bus.ly          = ly_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;
    assign bus.vblank      = vb_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_ydriver_ctrl.sv
// Bench for ydriver_ctrl on a shrunken panel (24 dots x 10 lines, 8 visible, fr period 3).
module tb_ydriver_ctrl;
    import lcd_timing_pkg::*;

    localparam int T_DOTS  = 24;
    localparam int T_LINES = 10;
    localparam int T_VIS   = 8;
    localparam int T_CKW   = 4;
    localparam int T_GAP   = 2;
    localparam int T_FRP   = 3;
    localparam int T_LYW   = $clog2(T_LINES);
    localparam int OUT_W   = 7 + T_LYW;
    localparam int W       = OUT_W + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ydriver_ctrl_if #(.LY_W(T_LYW)) bus ();
    ydrv_state_e dbg_state;

    ydriver_ctrl #(
        .DOTS      (T_DOTS),
        .LINES     (T_LINES),
        .VIS_LINES (T_VIS),
        .CK_W      (T_CKW),
        .GAP       (T_GAP),
        .FR_PERIOD (T_FRP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    bit m_run = 1'b0;
    int m_dot = 0;
    int m_abs_line = 0;

    bit agg_on = 1'b0;
    int ls_cnt = 0, fs_cnt = 0, s_cnt = 0, vb_cnt = 0, ck_cnt = 0, ovl_cnt = 0, frt_cnt = 0;
    int ck_in_line = 0, dots_in_line = 0;
    logic prev_fr = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // driver: one clock per call, expected outputs for that clock pushed before the edge
    task automatic step(input logic r, input logic e);
        logic [OUT_W-1:0] ev;
        int line;
        rst_n  = r;
        bus.en = e;
        if (!r || !e) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_dot = 0;
            m_abs_line = 0;
        end else begin
            m_dot++;
            if (m_dot == T_DOTS) begin
                m_dot = 0;
                m_abs_line++;
            end
        end
        if (m_run) begin
            line = m_abs_line % T_LINES;
            ev = {line == 0, (m_dot >= 2) && (m_dot <= 5), m_dot >= 8,
                  ((m_abs_line / T_FRP) % 2) == 1, T_LYW'(line),
                  m_dot == 0, (m_dot == 0) && (line == 0), line >= T_VIS};
        end else begin
            ev = {1'b0, 1'b0, 1'b1, 1'b0, {T_LYW{1'b0}}, 3'b000};
        end
        exp_q.push_back({m_run, ev});
        @(posedge clk);
        @(negedge clk);
    endtask

    // monitor: pops one expected vector per clock and compares the whole output set
    logic [W-1:0]     mon_e;
    logic [OUT_W-1:0] mon_act;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {bus.s, bus.ck, bus.cck, bus.fr, bus.ly, bus.line_start, bus.frame_start, bus.vblank};
            chk("outputs", mon_act, mon_e[OUT_W-1:0]);
            if (!mon_e[W-1]) begin
                ck_in_line   = 0;
                dots_in_line = 0;
            end else begin
                if (bus.line_start) begin
                    if (dots_in_line == T_DOTS) chk("ck_per_line", ck_in_line, T_CKW);
                    ck_in_line   = 0;
                    dots_in_line = 0;
                end
                dots_in_line++;
                ck_in_line += int'(bus.ck);
            end
            if (agg_on) begin
                ls_cnt  += int'(bus.line_start);
                fs_cnt  += int'(bus.frame_start);
                s_cnt   += int'(bus.s);
                vb_cnt  += int'(bus.vblank);
                ck_cnt  += int'(bus.ck);
                ovl_cnt += int'(bus.ck & bus.cck);
                frt_cnt += int'(bus.fr != prev_fr);
            end
            prev_fr = bus.fr;
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got %0d checks expected completion", chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0;
        @(negedge clk);

        // reset held with en already high
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_s", bus.s, 0);
        chk("rst_ck", bus.ck, 0);
        chk("rst_cck", bus.cck, 1);
        chk("rst_fr", bus.fr, 0);
        chk("rst_ly", bus.ly, 0);
        chk("rst_pulses", {bus.line_start, bus.frame_start, bus.vblank}, 0);
        chk("rst_state", dbg_state, ST_IDLE);

        repeat (3) step(1'b1, 1'b0);

        // start: first RUN cycle is dot 0 of line 0
        agg_on = 1'b1;
        step(1'b1, 1'b1);
        chk("start_fs", bus.frame_start, 1);
        chk("start_s", bus.s, 1);
        chk("start_ck", bus.ck, 0);
        chk("start_state", dbg_state, ST_RUN);

        repeat (T_DOTS * T_LINES - 1) step(1'b1, 1'b1);
        chk("f1_line_starts", ls_cnt, 10);
        chk("f1_frame_starts", fs_cnt, 1);
        chk("f1_s_cycles", s_cnt, 24);
        chk("f1_vblank_cycles", vb_cnt, 48);
        chk("f1_ck_cycles", ck_cnt, 40);
        chk("f1_fr_toggles", frt_cnt, 3);

        // first cycle of frame 2: ten lines in, three fr wraps so far
        step(1'b1, 1'b1);
        chk("f2_fs", bus.frame_start, 1);
        chk("f2_fr", bus.fr, 1);

        repeat (2 * T_DOTS * T_LINES - 1) step(1'b1, 1'b1);
        chk("f3_line_starts", ls_cnt, 30);
        chk("f3_frame_starts", fs_cnt, 3);
        chk("f3_s_cycles", s_cnt, 72);
        chk("f3_vblank_cycles", vb_cnt, 144);
        chk("f3_ck_cycles", ck_cnt, 120);
        chk("f3_overlap", ovl_cnt, 0);
        chk("f3_fr_toggles", frt_cnt, 9);
        agg_on = 1'b0;

        step(1'b1, 1'b0);

        // abort at line 5 dot 5, mid ck pulse
        repeat (1 + 5 * T_DOTS + 5) step(1'b1, 1'b1);
        chk("pre_abort_ck", bus.ck, 1);
        chk("pre_abort_ly", bus.ly, 5);
        step(1'b1, 1'b0);
        chk("abort_ck", bus.ck, 0);
        chk("abort_cck", bus.cck, 1);
        chk("abort_s", bus.s, 0);
        chk("abort_ly", bus.ly, 0);
        chk("abort_state", dbg_state, ST_IDLE);

        step(1'b1, 1'b1);
        chk("restart_fs", bus.frame_start, 1);
        chk("restart_ly", bus.ly, 0);
        chk("restart_fr", bus.fr, 0);

        repeat (30) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
